pwm_oc_multi: RTL and testbench

PWM_OC_MULTI -- requirements
Module: pwm_oc_multi

---
 rtl/pwm_oc_multi_if.sv | 30 +++
 rtl/pwm_oc_multi.sv | 113 +++++++++++
 tb/tb_pwm_oc_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pwm_oc_multi_if.sv
// Bus bundle for pwm_oc_multi: timebase, compare inputs, load strobe, channel
// controls and the registered PWM/status outputs.
interface pwm_oc_multi_if #(
   parameter int unsigned WIDTH  = 17,
   parameter int unsigned HRBITS = 3,
   parameter int unsigned NCH    = 4
) ();
   localparam int unsigned N = 1 << HRBITS;

   logic [WIDTH-HRBITS-1:0] tb;
   logic [NCH*WIDTH-1:0]    cmpH;
   logic [NCH*WIDTH-1:0]    cmpL;
   logic                    ld_req;
   logic [NCH-1:0]          en;
   logic [NCH-1:0]          inv;
   logic [NCH*N-1:0]        pwmD;
   logic [NCH-1:0]          falling;
   logic                    pending;
   logic                    upd;

   modport master (
      output tb, cmpH, cmpL, ld_req, en, inv,
      input  pwmD, falling, pending, upd
   );

   modport slave (
      input  tb, cmpH, cmpL, ld_req, en, inv,
      output pwmD, falling, pending, upd
   );
endinterface

// File: rtl/pwm_oc_multi.sv
// Multi-channel high-resolution output-compare PWM. Each channel emits an N-bit
// subsample word per clock; compares are double-buffered and swap at timebase wrap.
module pwm_oc_multi #(
   parameter int unsigned WIDTH  = 17,
   parameter int unsigned HRBITS = 3,
   parameter int unsigned NCH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   pwm_oc_multi_if.slave    bus
);
   localparam int unsigned N  = 1 << HRBITS;
   localparam int unsigned CW = WIDTH - HRBITS;

   logic [NCH*WIDTH-1:0] sh_h_q, sh_l_q;
   logic [NCH*WIDTH-1:0] act_h_q, act_l_q;
   logic                 pending_q, upd_q;
   logic [NCH-1:0]       x_q, x_d;
   logic [NCH-1:0]       fall_q, fall_d;
   logic [NCH*N-1:0]     pwm_q, pwm_d;
   logic                 xfer;

   assign xfer = pending_q && (bus.tb == {CW{1'b1}});

   always_comb begin
      logic [WIDTH-1:0]  h, l;
      logic [HRBITS-1:0] fh, fl;
      logic              hm, lm;
      logic [N-1:0]      rmask, fmask, raw;
      x_d    = x_q;
      fall_d = '0;
      pwm_d  = '0;
      h      = '0;
      l      = '0;
      fh     = '0;
      fl     = '0;
      hm     = 1'b0;
      lm     = 1'b0;
      rmask  = '0;
      fmask  = '0;
      raw    = '0;
      for (int k = 0; k < NCH; k++) begin
         h     = act_h_q[k*WIDTH +: WIDTH];
         l     = act_l_q[k*WIDTH +: WIDTH];
         fh    = h[HRBITS-1:0];
         fl    = l[HRBITS-1:0];
         hm    = (h[WIDTH-1:HRBITS] == bus.tb);
         lm    = (l[WIDTH-1:HRBITS] == bus.tb);
         rmask = {N{1'b1}} << fh;
         fmask = ~({N{1'b1}} << fl);
         raw   = {N{x_q[k]}};
         if (!bus.en[k]) begin
            raw    = '0;
            x_d[k] = 1'b0;
         end else if (hm && lm) begin
            // Both edges in one clock: a pulse only if rise precedes fall.
            if (fh < fl) begin
               raw       = rmask & fmask;
               x_d[k]    = 1'b0;
               fall_d[k] = 1'b1;
            end
         end else if (hm) begin
            raw    = rmask;
            x_d[k] = 1'b1;
         end else if (lm) begin
            raw       = fmask;
            x_d[k]    = 1'b0;
            fall_d[k] = 1'b1;
         end
         pwm_d[k*N +: N] = raw ^ {N{bus.inv[k]}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            sh_h_q[k*WIDTH +: WIDTH]  <= '0;
            sh_l_q[k*WIDTH +: WIDTH]  <= WIDTH'(50);
            act_h_q[k*WIDTH +: WIDTH] <= '0;
            act_l_q[k*WIDTH +: WIDTH] <= WIDTH'(50);
         end
         pending_q <= 1'b0;
         upd_q     <= 1'b0;
         x_q       <= '0;
         fall_q    <= '0;
         pwm_q     <= '0;
      end else begin
         // Transfer uses the shadow as it stood before any coincident load.
         if (xfer) begin
            act_h_q <= sh_h_q;
            act_l_q <= sh_l_q;
         end
         if (bus.ld_req) begin
            sh_h_q <= bus.cmpH;
            sh_l_q <= bus.cmpL;
         end
         if (bus.ld_req) begin
            pending_q <= 1'b1;
         end else if (xfer) begin
            pending_q <= 1'b0;
         end
         upd_q  <= xfer;
         x_q    <= x_d;
         fall_q <= fall_d;
         pwm_q  <= pwm_d;
      end
   end

   assign bus.pwmD    = pwm_q;
   assign bus.falling = fall_q;
   assign bus.pending = pending_q;
   assign bus.upd     = upd_q;
endmodule

// File: tb/tb_pwm_oc_multi.sv
// Directed bench for pwm_oc_multi: drives the timebase explicitly and checks
// hand-computed subsample words, fall pulses and the shadow-transfer handshake.
module tb_pwm_oc_multi;
   localparam int unsigned WIDTH  = 17;
   localparam int unsigned HRBITS = 3;
   localparam int unsigned NCH    = 4;
   localparam int unsigned CW     = WIDTH - HRBITS;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pwm_oc_multi_if #(.WIDTH(WIDTH), .HRBITS(HRBITS), .NCH(NCH)) bus ();

   pwm_oc_multi #(.WIDTH(WIDTH), .HRBITS(HRBITS), .NCH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present timebase value t, clock once, then sample the registered result for t.
   task automatic cyc(input logic [CW-1:0] t);
      bus.tb = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      bus.tb     = '0;
      bus.cmpH   = '0;
      bus.cmpL   = '0;
      bus.ld_req = 1'b0;
      bus.en     = '0;
      bus.inv    = '0;
      cyc(0);
      cyc(0);
      rst = 1'b0;
      chk("rst_pwmD", 32'(bus.pwmD), 32'h0);
      chk("rst_falling", 32'(bus.falling), 32'h0);
      chk("rst_pending", 32'(bus.pending), 32'h0);
      chk("rst_upd", 32'(bus.upd), 32'h0);

      // Ch0 0x13/0x55, ch1 0x18/0x40; load at tb 5, transfer at wrap.
      bus.cmpH[16:0]  = 17'h13;
      bus.cmpL[16:0]  = 17'h55;
      bus.cmpH[33:17] = 17'h18;
      bus.cmpL[33:17] = 17'h40;
      bus.ld_req = 1'b1;
      cyc(5);
      bus.ld_req = 1'b0;
      chk("ld_pending", 32'(bus.pending), 32'h1);
      chk("ld_no_out_change", 32'(bus.pwmD), 32'h0);
      cyc(6);
      chk("pending_hold", 32'(bus.pending), 32'h1);
      chk("upd_idle", 32'(bus.upd), 32'h0);
      cyc('1);
      chk("xfer_pending", 32'(bus.pending), 32'h0);
      chk("xfer_upd", 32'(bus.upd), 32'h1);
      bus.en[0] = 1'b1;
      cyc(0);
      chk("upd_one_cycle", 32'(bus.upd), 32'h0);
      cyc(1);
      chk("pre_rise", 32'(bus.pwmD[7:0]), 32'h00);
      cyc(2);
      chk("rise_word", 32'(bus.pwmD[7:0]), 32'hF8);
      for (int t = 3; t <= 9; t++) begin
         cyc(CW'(t));
         chk("high_word", 32'(bus.pwmD[7:0]), 32'hFF);
      end
      cyc(10);
      chk("fall_word", 32'(bus.pwmD[7:0]), 32'h1F);
      chk("fall_pulse", 32'(bus.falling), 32'h1);
      cyc(11);
      chk("low_word", 32'(bus.pwmD[7:0]), 32'h00);
      chk("fall_one_cycle", 32'(bus.falling), 32'h0);

      // Same-coarse pulse 0x21/0x26.
      bus.cmpH[16:0] = 17'h21;
      bus.cmpL[16:0] = 17'h26;
      bus.ld_req = 1'b1;
      cyc(12);
      bus.ld_req = 1'b0;
      cyc('1);
      for (int t = 0; t <= 3; t++) cyc(CW'(t));
      chk("narrow_pre", 32'(bus.pwmD[7:0]), 32'h00);
      cyc(4);
      chk("narrow_word", 32'(bus.pwmD[7:0]), 32'h3E);
      chk("narrow_fall", 32'(bus.falling), 32'h1);
      cyc(5);
      chk("narrow_after", 32'(bus.pwmD[7:0]), 32'h00);

      // Zero-width 0x21/0x21, loaded again on the transfer cycle.
      bus.cmpL[16:0] = 17'h21;
      bus.ld_req = 1'b1;
      cyc(6);
      cyc('1);
      bus.ld_req = 1'b0;
      chk("ld_on_xfer_pending", 32'(bus.pending), 32'h1);
      chk("ld_on_xfer_upd", 32'(bus.upd), 32'h1);
      for (int t = 0; t <= 3; t++) cyc(CW'(t));
      cyc(4);
      chk("zero_width_word", 32'(bus.pwmD[7:0]), 32'h00);
      chk("zero_width_fall", 32'(bus.falling), 32'h0);

      // Compare change without a load is ignored.
      bus.cmpH[16:0] = 17'h13;
      cyc(2);
      chk("no_ld_ignored", 32'(bus.pwmD[7:0]), 32'h00);

      // Disabled inverted channel 1 sits at all-ones.
      bus.inv[1] = 1'b1;
      cyc(7);
      chk("dis_inv_word", 32'(bus.pwmD[15:8]), 32'hFF);
      chk("dis_fall", 32'(bus.falling[1]), 32'h0);
      cyc('1);
      chk("second_xfer_pending", 32'(bus.pending), 32'h0);
      bus.inv[1] = 1'b0;
      bus.en[1]  = 1'b1;
      cyc(0);
      cyc(1);
      cyc(2);
      chk("reen_low", 32'(bus.pwmD[15:8]), 32'h00);
      cyc(3);
      chk("reen_rise", 32'(bus.pwmD[15:8]), 32'hFF);

      // Reset while ch0 is high.
      bus.cmpL[16:0] = 17'h55;
      bus.ld_req = 1'b1;
      cyc(5);
      bus.ld_req = 1'b0;
      cyc('1);
      for (int t = 0; t <= 1; t++) cyc(CW'(t));
      cyc(2);
      chk("pre_rst_rise", 32'(bus.pwmD[7:0]), 32'hF8);
      for (int t = 3; t <= 5; t++) cyc(CW'(t));
      chk("pre_rst_high", 32'(bus.pwmD[7:0]), 32'hFF);
      rst = 1'b1;
      cyc(6);
      rst = 1'b0;
      chk("rst_mid_pulse", 32'(bus.pwmD[7:0]), 32'h00);
      chk("rst_mid_fall", 32'(bus.falling), 32'h0);
      chk("rst_mid_pending", 32'(bus.pending), 32'h0);
      // Reset compares: rise at coarse 0 fine 0, fall at coarse 6 fine 2.
      cyc(0);
      chk("rst_act_rise", 32'(bus.pwmD[7:0]), 32'hFF);
      for (int t = 1; t <= 5; t++) cyc(CW'(t));
      chk("rst_act_high", 32'(bus.pwmD[7:0]), 32'hFF);
      cyc(6);
      chk("rst_act_fall", 32'(bus.pwmD[7:0]), 32'h03);
      chk("rst_act_fall_pulse", 32'(bus.falling[0]), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
